// File: rtl/coriolis_fpc_pkg.sv
// Shared definitions for FloPoCo <-> IEEE-754 single conversion.
// FloPoCo word layout: [33:32] exception, [31] sign, [30:23] exponent, [22:0] fraction.
package coriolis_fpc_pkg;

    localparam int FPC_W  = 34;
    localparam int IEEE_W = 32;

    localparam logic [IEEE_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        EXN_ZERO   = 2'b00,
        EXN_NORMAL = 2'b01,
        EXN_INF    = 2'b10,
        EXN_NAN    = 2'b11
    } exn_e;

endpackage

// File: rtl/coriolis_fpc2ieee_conv.sv
// Combinational FloPoCo-to-IEEE-754 single conversion.
// Zero and Inf keep the sign; NaN becomes the canonical quiet NaN (sign dropped).
module coriolis_fpc2ieee_conv
    import coriolis_fpc_pkg::*;
(
    input  logic [FPC_W-1:0]  fpc_in,
    output logic [IEEE_W-1:0] ieee_out
);

    logic sign;
    assign sign = fpc_in[IEEE_W-1];

    // Map the exception field onto the IEEE encoding.
    always_comb begin
        ieee_out = fpc_in[IEEE_W-1:0];
        case (exn_e'(fpc_in[FPC_W-1:IEEE_W]))
            EXN_ZERO:   ieee_out = {sign, 31'b0};
            EXN_NORMAL: ieee_out = fpc_in[IEEE_W-1:0];
            EXN_INF:    ieee_out = {sign, 8'hFF, 23'b0};
            EXN_NAN:    ieee_out = QNAN;
            default:    ieee_out = fpc_in[IEEE_W-1:0];
        endcase
    end

endmodule

// File: rtl/coriolis_ker1_subker0_fpc2ieee_buf.sv
// Output buffer for the divider: converts FloPoCo results to IEEE-754 single
// and queues them in a first-word-fall-through FIFO.
// Optional feature: define CORIOLIS_FPC_EXN_STATS_EN to add saturating
// NaN / Inf counters (nan_cnt, inf_cnt) on accepted words.
module coriolis_ker1_subker0_fpc2ieee_buf
    import coriolis_fpc_pkg::*;
#(
    parameter int STREAMW = 34,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ivalid,
    input  logic [STREAMW-1:0] idata,
    output logic               iready,
    output logic               ovalid,
    output logic [IEEE_W-1:0]  odata,
    input  logic               oready
`ifdef CORIOLIS_FPC_EXN_STATS_EN
    ,
    output logic [15:0]        nan_cnt,
    output logic [15:0]        inf_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q,  count_d;
    logic [IEEE_W-1:0] mem_q [DEPTH];
    logic [IEEE_W-1:0] conv_data;
    logic              push;
    logic              pop;

    coriolis_fpc2ieee_conv u_conv (
        .fpc_in   (idata[FPC_W-1:0]),
        .ieee_out (conv_data)
    );

    // Full blocks input regardless of a same-cycle pop (no pass-through).
    assign iready = (count_q != DEPTH_C);
    assign ovalid = (count_q != '0);
    assign push   = ivalid & iready;
    assign pop    = ovalid & oready;
    assign odata  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW+1)'(1);
        end
    end

    // Control state register; storage contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write of the already-converted word.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= conv_data;
        end
    end

`ifdef CORIOLIS_FPC_EXN_STATS_EN
    logic [15:0] nan_cnt_q, nan_cnt_d;
    logic [15:0] inf_cnt_q, inf_cnt_d;
    exn_e        in_exn;

    assign in_exn  = exn_e'(idata[FPC_W-1:IEEE_W]);
    assign nan_cnt = nan_cnt_q;
    assign inf_cnt = inf_cnt_q;

    // Saturating exception counters, counting accepted words only.
    always_comb begin
        nan_cnt_d = nan_cnt_q;
        inf_cnt_d = inf_cnt_q;
        if (push && in_exn == EXN_NAN && nan_cnt_q != 16'hFFFF) begin
            nan_cnt_d = nan_cnt_q + 16'd1;
        end
        if (push && in_exn == EXN_INF && inf_cnt_q != 16'hFFFF) begin
            inf_cnt_d = inf_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            nan_cnt_q <= '0;
            inf_cnt_q <= '0;
        end else begin
            nan_cnt_q <= nan_cnt_d;
            inf_cnt_q <= inf_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_coriolis_ker1_subker0_fpc2ieee_buf.sv
// Directed self-checking bench for coriolis_ker1_subker0_fpc2ieee_buf.
// Define CORIOLIS_FPC_EXN_STATS_EN to also exercise the exception counters.
module tb_coriolis_ker1_subker0_fpc2ieee_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        ivalid;
    logic [33:0] idata;
    logic        iready;
    logic        ovalid;
    logic [31:0] odata;
    logic        oready;
`ifdef CORIOLIS_FPC_EXN_STATS_EN
    logic [15:0] nan_cnt;
    logic [15:0] inf_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    coriolis_ker1_subker0_fpc2ieee_buf #(
        .STREAMW (34),
        .DEPTH   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ivalid  (ivalid),
        .idata   (idata),
        .iready  (iready),
        .ovalid  (ovalid),
        .odata   (odata),
        .oready  (oready)
`ifdef CORIOLIS_FPC_EXN_STATS_EN
        ,
        .nan_cnt (nan_cnt),
        .inf_cnt (inf_cnt)
`endif
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    logic [31:0] w [0:8];
    logic [31:0] a [0:7];

    initial begin
        rst    = 1'b1;
        ivalid = 1'b0;
        idata  = '0;
        oready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_iready", 32'(iready), 32'd1);

        // Pops on an empty buffer must be ignored.
        oready = 1'b1;
        tick();
        tick();
        chk("empty_pop", 32'(ovalid), 32'd0);

        // Single normal word, latency 1, then drained.
        ivalid = 1'b1;
        idata  = {2'b01, 32'h447A_0000};
        tick();
        ivalid = 1'b0;
        chk("lat1_ovalid", 32'(ovalid), 32'd1);
        chk("lat1_odata", odata, 32'h447A_0000);
        tick();
        chk("lat1_drained", 32'(ovalid), 32'd0);

        // Exception conversions: zero keeps sign, inf, NaN canonical.
        oready = 1'b0;
        ivalid = 1'b1;
        idata  = {2'b00, 32'h8000_1234};
        tick();
        idata  = {2'b10, 32'h0000_0000};
        tick();
        idata  = {2'b11, 32'h0000_0000};
        tick();
        ivalid = 1'b0;
        chk("conv_zero", odata, 32'h8000_0000);
        tick();
        chk("conv_hold", odata, 32'h8000_0000);
        oready = 1'b1;
        tick();
        chk("conv_inf", odata, 32'h7F80_0000);
        tick();
        chk("conv_nan", odata, 32'h7FC0_0000);
        tick();
        chk("conv_empty", 32'(ovalid), 32'd0);

        // Fill to full with oready low; ninth word must be held off.
        oready = 1'b0;
        for (int i = 0; i < 9; i++) w[i] = 32'h3F80_0000 + 32'(i);
        ivalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idata = {2'b01, w[i]};
            tick();
        end
        chk("full_iready", 32'(iready), 32'd0);
        idata = {2'b01, w[8]};
        tick();
        tick();
        chk("full_held", 32'(iready), 32'd0);
        oready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d", k), odata, w[k]);
            tick();
            if (k == 0) chk("after_pop_rdy", 32'(iready), 32'd1);
            if (k == 1) ivalid = 1'b0;
        end
        chk("ninth_word", odata, w[8]);
        tick();
        chk("ninth_drained", 32'(ovalid), 32'd0);

        // Occupancy 3 with simultaneous push/pop; pointers wrap.
        for (int i = 0; i < 8; i++) a[i] = 32'h4000_0000 + 32'(i << 4);
        oready = 1'b0;
        ivalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idata = {2'b01, a[i]};
            tick();
        end
        oready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            idata = {2'b01, a[3 + j]};
            chk($sformatf("pp_head%0d", j), odata, a[j]);
            chk($sformatf("pp_rdy%0d", j), 32'(iready), 32'd1);
            tick();
        end
        ivalid = 1'b0;
        for (int j = 5; j < 8; j++) begin
            chk($sformatf("pp_tail%0d", j), odata, a[j]);
            tick();
        end
        chk("pp_empty", 32'(ovalid), 32'd0);

        // Reset mid-operation discards stored words.
        oready = 1'b0;
        ivalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idata = {2'b01, 32'h1111_1111 * 32'(i + 1)};
            tick();
        end
        ivalid = 1'b0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        chk("mrst_ovalid", 32'(ovalid), 32'd0);
        chk("mrst_iready", 32'(iready), 32'd1);
        ivalid = 1'b1;
        idata  = {2'b10, 32'h8000_0000};
        tick();
        ivalid = 1'b0;
        oready = 1'b1;
        chk("mrst_first", odata, 32'hFF80_0000);
        chk("mrst_valid", 32'(ovalid), 32'd1);
        tick();
        chk("mrst_empty", 32'(ovalid), 32'd0);

`ifdef CORIOLIS_FPC_EXN_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stat_rst_nan", 32'(nan_cnt), 32'd0);
        chk("stat_rst_inf", 32'(inf_cnt), 32'd0);
        oready = 1'b1;
        ivalid = 1'b1;
        idata  = {2'b11, 32'h0};
        for (int i = 0; i < 3; i++) tick();
        idata  = {2'b10, 32'h0};
        for (int i = 0; i < 2; i++) tick();
        idata  = {2'b01, 32'h3F80_0000};
        tick();
        chk("stat_nan3", 32'(nan_cnt), 32'd3);
        chk("stat_inf2", 32'(inf_cnt), 32'd2);
        // 65535 more NaNs: an unsaturated counter would wrap to 2.
        idata = {2'b11, 32'h0};
        for (int i = 0; i < 65535; i++) tick();
        ivalid = 1'b0;
        tick();
        chk("stat_nan_sat", 32'(nan_cnt), 32'h0000_FFFF);
        chk("stat_inf_keep", 32'(inf_cnt), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/coriolis_ker1_subker0_fpc2ieee_buf.md
CORIOLIS_KER1_SUBKER0_FPC2IEEE_BUF -- requirements
Module: coriolis_ker1_subker0_fpc2ieee_buf

Interface
REQ-001 SHALL have parameter STREAMW, default 34: input width, FloPoCo word = 2-bit exception field + 32-bit IEEE payload.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO entries, power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port ivalid, input, 1 bit: upstream divider result valid.
REQ-006 SHALL have port idata, input, STREAMW bits: FloPoCo result; [33:32] exn, [31] sign, [30:23] exponent, [22:0] fraction.
REQ-007 SHALL have port iready, output, 1 bit: buffer can accept a word; drives the divider's oready.
REQ-008 SHALL have port ovalid, output, 1 bit: head entry is valid.
REQ-009 SHALL have port odata, output, 32 bits: IEEE-754 single value.
REQ-010 SHALL have port oready, input, 1 bit: downstream consumer ready.

Function
REQ-011 SHALL accept a word (push) in any cycle where ivalid and iready are both 1.
REQ-012 SHALL drive iready = 1 iff occupancy < DEPTH; no pass-through when full, even if a pop occurs in the same cycle.
REQ-013 SHALL complete a pop in any cycle where ovalid and oready are both 1.
REQ-014 SHALL drive ovalid = 1 iff occupancy > 0; head data SHALL be first-word-fall-through on odata.
REQ-015 SHALL present a word pushed into an empty buffer on ovalid/odata in the next cycle (latency 1 cycle).
REQ-016 SHALL convert each word before storage: exn 00 -> {sign, 31'b0}; exn 01 -> idata[31:0] unchanged; exn 10 -> {sign, 8'hFF, 23'b0}; exn 11 -> 32'h7FC00000 (canonical qNaN, sign dropped).
REQ-017 SHALL keep occupancy unchanged on a simultaneous push and pop, and SHALL preserve strict FIFO order.
REQ-018 SHALL use log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH, and a log2(DEPTH)+1-bit occupancy counter.
REQ-019 SHALL ignore pops when empty and pushes when full; neither pointer nor counter SHALL change in those cases.
REQ-020 SHALL hold odata stable while ovalid = 1 and oready = 0.

Reset
REQ-021 SHALL, on rst, clear the pointers and occupancy to 0, giving ovalid = 0 and iready = 1 in the cycle after rst is sampled.
REQ-022 SHALL, on rst mid-operation, discard all stored words; storage array contents need no reset, and odata is don't-care while ovalid = 0.

Configuration
REQ-023 SHALL provide the macro CORIOLIS_FPC_EXN_STATS_EN.
REQ-024 SHALL, with CORIOLIS_FPC_EXN_STATS_EN defined, add 16-bit output ports nan_cnt and inf_cnt.
REQ-025 SHALL, with the macro defined, increment each counter by 1 per accepted word with exn 11 or exn 10 respectively, saturate at 16'hFFFF, and clear both on rst.
REQ-026 SHALL, without the macro, omit both ports and both counters, with no other change in behaviour.

Structure
REQ-027 SHALL place the following in shared package coriolis_fpc_pkg: exn encodings (EXN_ZERO=2'b00, EXN_NORMAL=2'b01, EXN_INF=2'b10, EXN_NAN=2'b11), FPC_W=34, IEEE_W=32 and QNAN=32'h7FC00000.
REQ-028 SHALL implement the conversion as combinational sub-module coriolis_fpc2ieee_conv; FIFO control SHALL remain in this module.

Verification
REQ-029 SHALL cover: push {01,32'h447A0000} into an empty buffer with oready=1 -> next cycle ovalid=1, odata=32'h447A0000; following cycle ovalid=0.
REQ-030 SHALL cover: push {00,32'h80001234}, then {10,32'h00000000}, then {11,32'h00000000} -> odata sequence 32'h80000000, 32'h7F800000, 32'h7FC00000.
REQ-031 SHALL cover: oready=0 with 9 consecutive valid words -> iready falls after the 8th push and the 9th is held; then oready=1 -> all 8 drain in order, then the 9th is accepted.
REQ-032 SHALL cover: occupancy 3 with push and pop asserted together for 5 cycles -> occupancy stays 3, ordering correct, pointers wrap past 7 to 0.
REQ-033 SHALL cover: rst asserted with occupancy 5 -> next cycle ovalid=0, iready=1; a later push emerges as the first output.
REQ-034 SHALL cover, with CORIOLIS_FPC_EXN_STATS_EN defined: 3 NaN words and 2 Inf words -> nan_cnt=3, inf_cnt=2; nan_cnt forced to 16'hFFFE plus 3 NaN words -> nan_cnt=16'hFFFF.
